interrupt_controller: RTL

- Game Boy style interrupt controller that owns the IF (0xFF0F) and IE (0xFFFF) registers and the IME master enable.
- Collects request pulses from VBlank, STAT, Timer, Serial and Joypad, and resolves priority.
- Drives the ControlUnit interrupt inputs: `o_Pending` feeds `i_Interrupts`. It answers the CU's handle-interrupt acknowledge with a latched vector and clears the serviced IF bit.
- Sits between the peripherals, the memory-mapped register bus and the CPU ControlUnit.

---
 rtl/irq_pkg.sv | 29 ++
 rtl/irq_priority_encoder.sv | 25 ++
 rtl/interrupt_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants and state encodings for the interrupt controller slice.
// No logic, no latency.
// No flow control; constants only.
package irq_pkg;

    // Source indices; lower index wins priority.
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    // Memory-mapped register addresses decoded by the bus fabric.
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Master enable: ARMED models the one-instruction delay after EI.
    typedef enum logic [1:0] {
        IME_OFF   = 2'd0,
        IME_ARMED = 2'd1,
        IME_ON    = 2'd2
    } ime_state_t;

    typedef enum logic {
        DISP_IDLE     = 1'b0,
        DISP_DISPATCH = 1'b1
    } disp_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-set-bit encoder: bit 0 is the highest-priority source.
// Purely combinational, zero latency.
// No flow control; o_Valid low means no bit set and o_Index is 0.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 5,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] i_Bits,
    output logic [IDX_W-1:0]   o_Index,
    output logic               o_Valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_Index = '0;
        o_Valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_Bits[i]) begin
                o_Index = IDX_W'(i);
                o_Valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE/IME owner: edge-captures peripheral requests, resolves priority, latches the dispatch vector.
// Request edge to IF: 1 enabled clock; IF to o_Pending/o_Service: combinational; ack to o_Vector: 1 clock.
// No backpressure; i_Enable low freezes every register and acks in DISPATCH are dropped.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int         NUM_IRQ       = 5,
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter int         VECTOR_STRIDE = 8
) (
    input  logic               i_Clk,
    input  logic               i_nRst,
    input  logic               i_Enable,
    input  logic [NUM_IRQ-1:0] i_Request,
    input  logic               i_Sel_IF,
    input  logic               i_Sel_IE,
    input  logic               i_Write,
    input  logic [7:0]         i_Data,
    output logic [7:0]         o_Data,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic               i_Instr_End,
    input  logic               i_Ack,
    input  logic               i_Dispatch_Done,
    output logic [NUM_IRQ-1:0] o_Pending,
    output logic               o_Service,
    output logic [7:0]         o_Vector,
    output logic               o_Busy
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] r_req_q;
    logic [NUM_IRQ-1:0] r_if;
    logic [7:0]         r_ie;
    logic [7:0]         r_vector;
    ime_state_t         r_ime_state;
    disp_state_t        r_disp_state;

    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_if_next;
    logic [7:0]         w_ie_next;
    logic [7:0]         w_vector_next;
    logic [7:0]         w_vector_calc;
    logic [7:0]         w_if_read;
    logic [IDX_W-1:0]   w_idx;
    logic               w_pend_vld;
    logic               w_ack_fire;
    ime_state_t         w_ime_next;
    disp_state_t        w_disp_next;

    assign w_pending  = r_if & r_ie[NUM_IRQ-1:0];
    assign w_edge     = i_Request & ~r_req_q;
    assign w_ack_fire = i_Ack & (r_disp_state == DISP_IDLE);

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_enc (
        .i_Bits  (w_pending),
        .o_Index (w_idx),
        .o_Valid (w_pend_vld)
    );

    assign w_vector_calc = VECTOR_BASE + 8'(VECTOR_STRIDE) * 8'(w_idx);

    // IF/IE next value: ack clear, then bus write, then new edges on top so an edge is never lost.
    always_comb begin
        w_if_next = r_if;
        if (w_ack_fire && w_pend_vld) begin
            w_if_next[w_idx] = 1'b0;
        end
        if (i_Sel_IF && i_Write) begin
            w_if_next = i_Data[NUM_IRQ-1:0];
        end
        w_if_next = w_if_next | w_edge;
        w_ie_next = (i_Sel_IE && i_Write) ? i_Data : r_ie;
    end

    // Request history, IF, IE and the latched vector.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_req_q  <= '0;
            r_if     <= '0;
            r_ie     <= '0;
            r_vector <= '0;
        end else if (i_Enable) begin
            r_req_q  <= i_Request;
            r_if     <= w_if_next;
            r_ie     <= w_ie_next;
            r_vector <= w_vector_next;
        end
    end

    // IME state register.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_ime_state <= IME_OFF;
        end else if (i_Enable) begin
            r_ime_state <= w_ime_next;
        end
    end

    // IME next state: DI dominates, dispatch disables, RETI enables, EI arms until the next opcode boundary.
    always_comb begin
        w_ime_next = r_ime_state;
        if (i_DI) begin
            w_ime_next = IME_OFF;
        end else if (w_ack_fire) begin
            w_ime_next = IME_OFF;
        end else if (i_RETI) begin
            w_ime_next = IME_ON;
        end else begin
            case (r_ime_state)
                IME_OFF:   if (i_EI) w_ime_next = IME_ARMED;
                IME_ARMED: if (i_Instr_End) w_ime_next = IME_ON;
                default:   w_ime_next = r_ime_state;
            endcase
        end
    end

    // Dispatch state register.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_disp_state <= DISP_IDLE;
        end else if (i_Enable) begin
            r_disp_state <= w_disp_next;
        end
    end

    // Dispatch next state and vector capture; a cancelled ack (nothing pending) still dispatches to 0x0000.
    always_comb begin
        w_disp_next   = r_disp_state;
        w_vector_next = r_vector;
        case (r_disp_state)
            DISP_IDLE: begin
                if (i_Ack) begin
                    w_disp_next   = DISP_DISPATCH;
                    w_vector_next = w_pend_vld ? w_vector_calc : 8'h00;
                end
            end
            DISP_DISPATCH: begin
                if (i_Dispatch_Done) begin
                    w_disp_next = DISP_IDLE;
                end
            end
            default: w_disp_next = DISP_IDLE;
        endcase
    end

    // Bus read mux; unused IF bits read as 1.
    always_comb begin
        w_if_read              = 8'hFF;
        w_if_read[NUM_IRQ-1:0] = r_if;
        if (i_Sel_IF) begin
            o_Data = w_if_read;
        end else if (i_Sel_IE) begin
            o_Data = r_ie;
        end else begin
            o_Data = 8'h00;
        end
    end

    assign o_Pending = w_pending;
    assign o_Service = (r_ime_state == IME_ON) & w_pend_vld & (r_disp_state == DISP_IDLE);
    assign o_Vector  = r_vector;
    assign o_Busy    = (r_disp_state == DISP_DISPATCH);

endmodule
